// File: rtl/issue_scoreboard.sv
// Register-dependency scoreboard between decode and execute.
// Tracks how many writes are in flight to each architectural register and
// stalls decode on read-after-write, full per-register write slots, or a
// full machine-wide in-flight budget. Register 0 is never tracked.
module issue_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 2,
    parameter int MAX_INFLIGHT   = 4,
    parameter int TOT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic                      rs1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic                      rs2_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      rd_valid,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush,
    output logic                      hazard_stall,
    output logic                      issue_fire,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [TOT_WIDTH-1:0]      inflight,
    output logic                      wb_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [TOT_WIDTH-1:0] TOT_MAX = TOT_WIDTH'(MAX_INFLIGHT);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic [TOT_WIDTH-1:0] inflight_q;
    logic [TOT_WIDTH-1:0] inflight_d;
    logic                 wb_err_q;
    logic                 wb_err_d;

    logic raw1;
    logic raw2;
    logic waw_full;
    logic tot_full;
    logic alloc;
    logic wb_hit;
    logic release_wb;
    logic bad_wb;

    // Hazard detection looks only at registered state, so a same-cycle writeback never unblocks.
    always_comb begin
        raw1     = rs1_valid && (rs1 != '0) && (cnt_q[rs1] != '0);
        raw2     = rs2_valid && (rs2 != '0) && (cnt_q[rs2] != '0);
        waw_full = rd_valid && (rd != '0) && (cnt_q[rd] == CNT_MAX);
        tot_full = rd_valid && (rd != '0) && (inflight_q == TOT_MAX);

        hazard_stall = dec_valid && !flush && (raw1 || raw2 || waw_full || tot_full);
        issue_fire   = dec_valid && !flush && !hazard_stall;

        alloc      = issue_fire && rd_valid && (rd != '0);
        wb_hit     = wb_valid && !flush && (wb_rd != '0);
        release_wb = wb_hit && (cnt_q[wb_rd] != '0);
        bad_wb     = wb_hit && (cnt_q[wb_rd] == '0);
    end

    // Per-register counter next state: allocate and release on the same register cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else begin
                if (alloc && (rd == REG_ADDR_WIDTH'(i)) &&
                    !(release_wb && (wb_rd == REG_ADDR_WIDTH'(i)))) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end else if (release_wb && (wb_rd == REG_ADDR_WIDTH'(i)) &&
                             !(alloc && (rd == REG_ADDR_WIDTH'(i)))) begin
                    cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // Total in-flight count moves by the net of allocate and release; errors are sticky.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (alloc && !release_wb) begin
            inflight_d = inflight_q + TOT_WIDTH'(1);
        end else if (release_wb && !alloc) begin
            inflight_d = inflight_q - TOT_WIDTH'(1);
        end
        wb_err_d = wb_err_q || bad_wb;
    end

    // State registers, cleared immediately by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // Busy bits are a direct view of the counter flops.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end
    end

    assign inflight = inflight_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: a driver applies directed and random
// decode/writeback traffic and pushes the expected response from an
// integer-array reference model; a monitor pops and compares each cycle.
module tb_issue_scoreboard;

    localparam int NUM_REGS = 32;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  rs1;
    logic        rs1_valid;
    logic [4:0]  rs2;
    logic        rs2_valid;
    logic [4:0]  rd;
    logic        rd_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        hazard_stall;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [2:0]  inflight;
    logic        wb_err;

    typedef struct {
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic [2:0]  tot;
        logic        err;
    } exp_t;

    exp_t expQ[$];

    int checksTotal  = 0;
    int checksPassed = 0;

    int  cntM [NUM_REGS];
    int  totM;
    bit  errM;

    issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .rs1          (rs1),
        .rs1_valid    (rs1_valid),
        .rs2          (rs2),
        .rs2_valid    (rs2_valid),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .issue_fire   (issue_fire),
        .busy_vec     (busy_vec),
        .inflight     (inflight),
        .wb_err       (wb_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) cntM[i] = 0;
        totM = 0;
        errM = 1'b0;
    endtask

    // Drive one cycle of inputs just after a rising edge, predict the visible
    // response from the model, queue it, then advance the model to the next edge.
    task automatic applyStimulus(input bit dv, input int r1, input bit r1v, input int r2, input bit r2v,
                                 input int d, input bit dVal, input bit wbv, input int wbr, input bit fl);
        exp_t e;
        bit   hz;
        bit   fire;
        bit   relOk;
        @(posedge clk);
        #1;
        dec_valid = dv;  rs1 = 5'(r1); rs1_valid = r1v; rs2 = 5'(r2); rs2_valid = r2v;
        rd = 5'(d); rd_valid = dVal; wb_valid = wbv; wb_rd = 5'(wbr); flush = fl;

        hz = (r1v && r1 != 0 && cntM[r1] > 0) ||
             (r2v && r2 != 0 && cntM[r2] > 0) ||
             (dVal && d != 0 && (cntM[d] == 3 || totM == 4));
        hz   = dv && !fl && hz;
        fire = dv && !fl && !hz;

        e.stall = hz;
        e.fire  = fire;
        e.tot   = 3'(totM);
        e.err   = errM;
        e.busy  = '0;
        for (int i = 0; i < NUM_REGS; i++) e.busy[i] = (cntM[i] > 0);
        expQ.push_back(e);

        if (fl) begin
            for (int i = 0; i < NUM_REGS; i++) cntM[i] = 0;
            totM = 0;
        end else begin
            relOk = wbv && wbr != 0 && cntM[wbr] > 0;
            if (wbv && wbr != 0 && !relOk) errM = 1'b1;
            if (fire && dVal && d != 0) begin
                cntM[d]++;
                totM++;
            end
            if (relOk) begin
                cntM[wbr]--;
                totM--;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issueRd(input int d);
        applyStimulus(1, 0, 0, 0, 0, d, 1, 0, 0, 0);
    endtask

    task automatic writeback(input int r);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("hazard_stall", 32'(hazard_stall), 32'(e.stall));
                checkOutput("issue_fire",   32'(issue_fire),   32'(e.fire));
                checkOutput("busy_vec",     busy_vec,          e.busy);
                checkOutput("inflight",     32'(inflight),     32'(e.tot));
                checkOutput("wb_err",       32'(wb_err),       32'(e.err));
            end
        end
    end

    // Directed scenarios, an asynchronous reset check, then randomized traffic.
    initial begin
        int pend[$];
        int a, b, c;
        bit wbv, fl;
        int wbr;

        reset = 1'b0;
        dec_valid = 0; rs1 = 0; rs1_valid = 0; rs2 = 0; rs2_valid = 0;
        rd = 0; rd_valid = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        modelReset();
        #22;
        reset = 1'b1;

        idleCycle();
        issueRd(5);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

        issueRd(7);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        writeback(7);

        issueRd(3); issueRd(3); issueRd(3);
        issueRd(3);
        issueRd(10);
        issueRd(9);
        applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        writeback(3); writeback(3); writeback(3); writeback(10);

        applyStimulus(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        writeback(12);
        idleCycle();

        issueRd(1); issueRd(2); issueRd(4);
        applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
        idleCycle();

        issueRd(5); issueRd(6);
        idleCycle();

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_busy",     busy_vec,         32'h0);
        checkOutput("async_inflight", 32'(inflight),    32'h0);
        checkOutput("async_wb_err",   32'(wb_err),      32'h0);
        modelReset();
        #1;
        reset = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            pend.delete();
            for (int i = 1; i < NUM_REGS; i++) if (cntM[i] > 0) pend.push_back(i);
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            wbv = ($urandom_range(0, 99) < 40);
            if (pend.size() > 0 && $urandom_range(0, 99) < 90)
                wbr = pend[$urandom_range(0, pend.size() - 1)];
            else
                wbr = $urandom_range(0, 15);
            fl = ($urandom_range(0, 99) < 3);
            applyStimulus(($urandom_range(0, 99) < 80), a, 1'($urandom), b, 1'($urandom),
                          c, ($urandom_range(0, 99) < 75), wbv, wbr, fl);
        end
        idleCycle();

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-dependency scoreboard that gates issue from the decode stage into the execution unit.
- Tracks outstanding writes to each architectural register. When a decoded instruction's valid sources, or its destination, conflict with in-flight writes, it raises a stall back into the decoder.
- Retires entries on writeback and clears everything on pipeline flush.
- Sits between the decoder's register-address outputs and its system stall input, in parallel with the register file read.

Parameters:
- NUM_REGS, 32, number of architectural registers
- REG_ADDR_WIDTH, 5, register address width (log2 NUM_REGS)
- CNT_WIDTH, 2, per-register outstanding-write counter width; max per-register pending = 2^CNT_WIDTH-1
- MAX_INFLIGHT, 4, max total outstanding writes across all registers
- TOT_WIDTH, 3, width of total in-flight counter (must hold MAX_INFLIGHT)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- dec_valid  input  1  decoder presents a decoded instruction this cycle
- rs1  input  REG_ADDR_WIDTH  source 1 address
- rs1_valid  input  1  rs1 used by instruction
- rs2  input  REG_ADDR_WIDTH  source 2 address
- rs2_valid  input  1  rs2 used by instruction
- rd  input  REG_ADDR_WIDTH  destination address
- rd_valid  input  1  rd written by instruction
- wb_valid  input  1  writeback completes this cycle
- wb_rd  input  REG_ADDR_WIDTH  writeback destination
- flush  input  1  squash all in-flight state (branch redirect)
- hazard_stall  output  1  combinational; hold decode
- issue_fire  output  1  combinational; instruction accepted this cycle
- busy_vec  output  NUM_REGS  registered; bit i = counter[i] != 0
- inflight  output  TOT_WIDTH  registered total outstanding writes
- wb_err  output  1  sticky; writeback to a non-pending register

Behaviour:
- Reset (reset=0, asynchronous): all per-register counters = 0, inflight = 0, busy_vec = 0, wb_err = 0. hazard_stall and issue_fire derive from state and inputs, so both are 0 while dec_valid=0.
- Register 0 is never tracked. rd=0, rs1=0 or rs2=0 never causes a hazard, and an issue with rd=0 allocates nothing.
- Hazard conditions:
  - raw1 = rs1_valid & rs1!=0 & cnt[rs1]!=0
  - raw2 = rs2_valid & rs2!=0 & cnt[rs2]!=0
  - waw_full = rd_valid & rd!=0 & cnt[rd]==max
  - tot_full = rd_valid & rd!=0 & inflight==MAX_INFLIGHT
- hazard_stall = dec_valid & ~flush & (raw1 | raw2 | waw_full | tot_full). Zero latency; computed only from registered state. A writeback in the same cycle does not unblock; there is no bypass, and release happens the following cycle.
- issue_fire = dec_valid & ~flush & ~hazard_stall.
- Allocate = issue_fire & rd_valid & rd!=0. Release = wb_valid & wb_rd!=0 & cnt[wb_rd]!=0.
- Per-register counter update each cycle:
  - +1 on allocate to that register
  - -1 on release from that register
  - both in the same cycle, same register: unchanged
- inflight updates as +allocate - release, net.
- Writeback with wb_rd!=0 and cnt[wb_rd]==0: counters untouched (no underflow), wb_err set to 1 and held until reset.
- Flush: at the next edge all counters = 0 and inflight = 0. Issue and writeback in the flush cycle are ignored, and the flush does not set wb_err. Writebacks after a flush that hit zeroed counters set wb_err. The pipeline owner must suppress wb_valid for squashed ops.
- Stall is level-based: the decoder holds its inputs while hazard_stall=1. The block keeps no memory of stalled requests.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset, then issue rd=5 (rs unused) -> issue_fire=1. Next cycle busy_vec[5]=1, inflight=1. Then issue rs1=5 rs1_valid=1 -> hazard_stall=1, issue_fire=0.
- With cnt[5]=1: wb_valid wb_rd=5 while dec holds rs1=5 -> stall=1 that cycle. Next cycle busy_vec[5]=0 and stall=0, fire=1.
- Same cycle: issue rd=7 with wb_rd=7 and cnt[7]=1 -> cnt[7] stays 1, inflight unchanged, busy_vec[7]=1.
- Issue rd=3 three times (CNT_WIDTH=2) -> cnt[3]=3. A fourth issue rd=3 -> hazard_stall=1 (waw_full). Issue four distinct rd -> inflight=4; a fifth rd=9 -> stall (tot_full).
- rs1=0 rs2=0 rd=0 all valid, dec_valid=1 -> fire=1, no state change. wb_valid wb_rd=12 with cnt[12]=0 -> wb_err=1 and stays 1.
- inflight=3, flush=1 with dec_valid=1 rd=4 -> fire=0. Next cycle busy_vec=0, inflight=0. Assert reset=0 asynchronously mid-cycle with busy state -> outputs clear before the next clk edge.
